// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the FSM state encoding and the RV32I load/store funct3 codes
// that the top level and the lane-alignment logic both decode.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT_R = 2'd2,
      DONE   = 2'd3
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic for the load/store unit.
// Ports:
//   store      in  1 = store access, 0 = load access
//   funct3     in  RV32I size/sign code
//   offset     in  byte offset within the word (addr[1:0])
//   wdata      in  right-justified store data
//   rdata      in  raw word returned by memory
//   be         out byte enables for the memory access
//   wdata_lane out store data replicated across all lanes (0 for loads)
//   rdata_ext  out lane-selected, sign/zero-extended load data
//   illegal    out access is misaligned or funct3 is not a valid code
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
   input  logic                  store,
   input  logic [2:0]            funct3,
   input  logic [1:0]            offset,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [BE_WIDTH-1:0]   be,
   output logic [DATA_WIDTH-1:0] wdata_lane,
   output logic [DATA_WIDTH-1:0] rdata_ext,
   output logic                  illegal
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (offset)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      be         = '0;
      wdata_lane = '0;
      rdata_ext  = '0;
      illegal    = 1'b0;

      // Size / alignment check and load extension share the funct3 decode;
      // funct3[2] selects zero extension for the unsigned variants.
      case (funct3)
         F3_B, F3_BU: begin
            rdata_ext = funct3[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         end
         F3_H, F3_HU: begin
            illegal   = offset[0];
            rdata_ext = funct3[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
         end
         F3_W: begin
            illegal   = (offset != 2'd0);
            rdata_ext = rdata;
         end
         default: illegal = 1'b1;
      endcase

      if (store) begin
         // Stores have no unsigned variants.
         if (funct3[2])
            illegal = 1'b1;
         case (funct3[1:0])
            2'd0: begin
               be         = BE_WIDTH'(4'b0001 << offset);
               wdata_lane = {4{wdata[7:0]}};
            end
            2'd1: begin
               be         = offset[1] ? BE_WIDTH'(4'b1100) : BE_WIDTH'(4'b0011);
               wdata_lane = {2{wdata[15:0]}};
            end
            default: begin
               be         = '1;
               wdata_lane = wdata;
            end
         endcase
      end else begin
         be = '1;
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory interface.
// Accepts one request at a time from the execute stage, issues a single
// word-aligned memory access with byte enables and returns extended load
// data (or an error for misaligned / illegal accesses) as a one-cycle pulse.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/ready   core request handshake
//   req_store         1 = store, 0 = load
//   req_funct3        RV32I size/sign code
//   req_addr          byte address
//   req_wdata         right-justified store data
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_err          misaligned or illegal access
//   mem_req/gnt       memory request handshake
//   mem_we, mem_be    write enable, byte enables
//   mem_addr          word-aligned address
//   mem_wdata         lane-replicated store data
//   mem_rvalid/rdata  read data return
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_store,
   input  logic [2:0]            req_funct3,
   input  logic [DATA_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mem_req,
   input  logic                  mem_gnt,
   output logic                  mem_we,
   output logic [BE_WIDTH-1:0]   mem_be,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   lsu_state_t            state;
   logic                  store_q;
   logic [2:0]            funct3_q;
   logic [DATA_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;

   logic                  in_idle;
   logic                  sel_store;
   logic [2:0]            sel_funct3;
   logic [1:0]            sel_offset;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [BE_WIDTH-1:0]   lane_be;
   logic [DATA_WIDTH-1:0] lane_wdata;
   logic [DATA_WIDTH-1:0] lane_rdata;
   logic                  lane_illegal;

   // In IDLE the aligner looks at the incoming request so the legality
   // decision is ready at the accept edge; afterwards it sees the latched
   // copy, which keeps mem_* stable while waiting for the grant.
   assign in_idle    = (state == IDLE);
   assign sel_store  = in_idle ? req_store       : store_q;
   assign sel_funct3 = in_idle ? req_funct3      : funct3_q;
   assign sel_offset = in_idle ? req_addr[1:0]   : addr_q[1:0];
   assign sel_wdata  = in_idle ? req_wdata       : wdata_q;

   lsu_lane_align #(
      .DATA_WIDTH (DATA_WIDTH),
      .BE_WIDTH   (BE_WIDTH)
   ) u_lane_align (
      .store      (sel_store),
      .funct3     (sel_funct3),
      .offset     (sel_offset),
      .wdata      (sel_wdata),
      .rdata      (mem_rdata),
      .be         (lane_be),
      .wdata_lane (lane_wdata),
      .rdata_ext  (lane_rdata),
      .illegal    (lane_illegal)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         store_q  <= 1'b0;
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  store_q  <= req_store;
                  funct3_q <= req_funct3;
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  rdata_q  <= '0;
                  err_q    <= lane_illegal;
                  state    <= lane_illegal ? DONE : ISSUE;
               end
            end
            ISSUE: begin
               if (mem_gnt)
                  state <= store_q ? DONE : WAIT_R;
            end
            WAIT_R: begin
               if (mem_rvalid) begin
                  rdata_q <= lane_rdata;
                  state   <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Moore outputs decoded from the state register and latched request.
   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == DONE);
   assign resp_rdata = (state == DONE) ? rdata_q : '0;
   assign resp_err   = (state == DONE) & err_q;

   assign mem_req    = (state == ISSUE);
   assign mem_we     = mem_req & store_q;
   assign mem_be     = mem_req ? lane_be : '0;
   assign mem_addr   = mem_req ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
   assign mem_wdata  = (mem_req & store_q) ? lane_wdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_req;
   logic        mem_gnt;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_req    (mem_req),
      .mem_gnt    (mem_gnt),
      .mem_we     (mem_we),
      .mem_be     (mem_be),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: describes an access by its size in bytes and its
   // byte offset, then derives lanes and extension arithmetically.
   task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd,
                        output bit ill, output logic [3:0] be,
                        output logic [31:0] mwd, output logic [31:0] res);
      int     size;
      bit     uns;
      int     o;
      longint val;
      size = 0;
      uns  = 1'b0;
      o    = int'(a % 4);
      case (f3)
         3'd0: size = 1;
         3'd1: size = 2;
         3'd2: size = 4;
         3'd4: begin size = 1; uns = 1'b1; end
         3'd5: begin size = 2; uns = 1'b1; end
         default: size = 0;
      endcase
      ill = (size == 0) || (st && f3 > 3'd2) || ((o % (size == 0 ? 1 : size)) != 0);
      be  = 4'hF;
      mwd = '0;
      res = '0;
      if (!ill) begin
         if (st) begin
            be = 4'(((1 << size) - 1) << o);
            for (int i = 0; i < 4; i++)
               mwd[8*i +: 8] = wd[8*(i % size) +: 8];
         end else begin
            val = (longint'(rd) >> (8 * o)) & ((64'd1 << (8 * size)) - 1);
            if (!uns && size < 4 && val >= (64'd1 << (8 * size - 1)))
               val = val - (64'd1 << (8 * size));
            res = val[31:0];
         end
      end
   endtask

   // One full transaction. gd = cycles mem_gnt is held low before the
   // grant, rvd = cycles between grant and mem_rvalid (0 = next cycle).
   task automatic txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd,
                      input int gd, input int rvd);
      bit          ill;
      logic [3:0]  be;
      logic [31:0] mwd;
      logic [31:0] res;
      model(st, f3, a, wd, rd, ill, be, mwd, res);
      @(negedge clk);
      check("idle_ready", 32'(req_ready), 32'd1);
      check("idle_resp_valid", 32'(resp_valid), 32'd0);
      check("idle_mem_req", 32'(mem_req), 32'd0);
      req_valid  = 1'b1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      // Scramble request inputs so anything not latched shows up.
      req_valid  = 1'b0;
      req_store  = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      if (!ill) begin
         for (int k = 0; k <= gd; k++) begin
            mem_gnt    = (k == gd);
            mem_rvalid = 1'($urandom);
            mem_rdata  = $urandom;
            @(negedge clk);
            check("iss_mem_req", 32'(mem_req), 32'd1);
            check("iss_mem_we", 32'(mem_we), 32'(st));
            check("iss_mem_be", 32'(mem_be), 32'(be));
            check("iss_mem_addr", mem_addr, {a[31:2], 2'b00});
            check("iss_mem_wdata", mem_wdata, mwd);
            check("iss_ready", 32'(req_ready), 32'd0);
            check("iss_resp_valid", 32'(resp_valid), 32'd0);
            @(posedge clk);
            #1;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
         end
         if (!st) begin
            for (int k = 0; k <= rvd; k++) begin
               mem_rvalid = (k == rvd);
               mem_rdata  = (k == rvd) ? rd : $urandom;
               @(negedge clk);
               check("wait_mem_req", 32'(mem_req), 32'd0);
               check("wait_resp_valid", 32'(resp_valid), 32'd0);
               @(posedge clk);
               #1;
               mem_rvalid = 1'b0;
               mem_rdata  = $urandom;
            end
         end
      end
      // Late/spurious rvalid during the response cycle must be ignored.
      mem_rvalid = 1'($urandom);
      @(negedge clk);
      check("done_resp_valid", 32'(resp_valid), 32'd1);
      check("done_resp_err", 32'(resp_err), 32'(ill));
      check("done_resp_rdata", resp_rdata, res);
      check("done_mem_req", 32'(mem_req), 32'd0);
      check("done_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_store  = 1'b0;
      req_funct3 = '0;
      req_addr   = '0;
      req_wdata  = '0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_be", 32'(mem_be), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed cases.
      txn(1'b1, 3'd0, 32'h0000_0013, 32'h0000_00AB, 32'h0, 0, 0);   // SB
      txn(1'b0, 3'd0, 32'h0000_0021, 32'h0, 32'h1234_80FF, 0, 0);   // LB
      txn(1'b0, 3'd4, 32'h0000_0021, 32'h0, 32'h1234_80FF, 0, 0);   // LBU
      txn(1'b0, 3'd1, 32'h0000_0042, 32'h0, 32'h8001_0000, 0, 0);   // LH
      txn(1'b0, 3'd5, 32'h0000_0042, 32'h0, 32'h8001_0000, 0, 0);   // LHU
      txn(1'b0, 3'd2, 32'h0000_0006, 32'h0, 32'h0, 0, 0);           // LW misaligned
      txn(1'b0, 3'd3, 32'h0000_0008, 32'h0, 32'h0, 0, 0);           // funct3=3 load
      txn(1'b1, 3'd1, 32'h0000_0001, 32'h0000_1234, 32'h0, 0, 0);   // SH misaligned
      txn(1'b1, 3'd2, 32'hDEAD_BEE0, 32'hCAFE_F00D, 32'h0, 5, 0);   // SW, slow grant
      txn(1'b1, 3'd1, 32'h0000_0102, 32'h0000_BEEF, 32'h0, 1, 0);   // SH upper half
      txn(1'b0, 3'd2, 32'h0000_0200, 32'h0, 32'h8765_4321, 2, 3);   // LW with delays

      // Reset while a load waits for rvalid.
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      mem_gnt   = 1'b1;
      @(posedge clk);
      #1;
      mem_gnt = 1'b0;
      @(negedge clk);
      check("rstmid_wait_mem_req", 32'(mem_req), 32'd0);
      check("rstmid_wait_ready", 32'(req_ready), 32'd0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rstmid_ready", 32'(req_ready), 32'd1);
      check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
      check("rstmid_mem_req", 32'(mem_req), 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h5555_AAAA;
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rstmid_late_resp_valid", 32'(resp_valid), 32'd0);
         check("rstmid_late_ready", 32'(req_ready), 32'd1);
         check("rstmid_late_mem_req", 32'(mem_req), 32'd0);
      end

      // Reset while a store waits for its grant.
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40;
      req_wdata = 32'h1111_2222;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("rstiss_mem_req", 32'(mem_req), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rstiss_after_mem_req", 32'(mem_req), 32'd0);
      check("rstiss_after_ready", 32'(req_ready), 32'd1);
      check("rstiss_after_resp", 32'(resp_valid), 32'd0);
      @(posedge clk);
      #1;

      // Randomized transactions.
      for (int n = 0; n < 80; n++) begin
         logic [31:0] ra;
         ra = $urandom;
         if ($urandom_range(0, 1) == 0)
            ra[1:0] = 2'd0;
         txn(1'($urandom), 3'($urandom), ra, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: takes one load/store request from the core per transaction, drives word-aligned memory accesses with byte enables, and returns extended load data.
- Sits between the execute stage and the data memory.
- Covers RV32I LB/LH/LW/LBU/LHU/SB/SH/SW with misalignment detection.
- Single outstanding transaction; multi-cycle, handshake-based.

Parameters:
- DATA_WIDTH, 32, data/address width; only 32 is supported.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  LSU can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (size/sign).
- req_addr  in  DATA_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access or illegal funct3, qualified by resp_valid.
- mem_req  out  1  memory access request.
- mem_gnt  in  1  memory accepted the request.
- mem_we  out  1  write enable.
- mem_be  out  BE_WIDTH  byte enables.
- mem_addr  out  DATA_WIDTH  word address {req_addr[31:2],2'b00}.
- mem_wdata  out  DATA_WIDTH  lane-replicated store data.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_WIDTH  read word.

Behaviour:
- States: IDLE, ISSUE, WAIT_R, DONE.
- Reset (rst_n=0 at a clk edge): state becomes IDLE. All outputs are 0 except req_ready, which is 1. Latched request registers clear to 0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch store, funct3, addr and wdata.
  - If the access is illegal, go to DONE with err=1 and make no memory access. Illegal means: load funct3 in {3,6,7}, store funct3 >2, half access with addr[0]=1, or word access with addr[1:0]!=0.
  - Otherwise go to ISSUE.
- ISSUE:
  - mem_req=1. mem_we, mem_be, mem_addr and mem_wdata hold stable until mem_gnt.
  - On mem_gnt: a store goes to DONE; a load goes to WAIT_R.
  - mem_gnt in the same cycle as entry counts.
- WAIT_R:
  - mem_req=0.
  - On mem_rvalid, capture the lane-selected, extended data and go to DONE.
  - mem_rvalid in any other state is ignored.
- DONE: resp_valid=1 for exactly one cycle with resp_rdata/resp_err, then IDLE. req_ready=0 in ISSUE, WAIT_R and DONE.
- Latency (accept edge = cycle 0):
  - Store with immediate grant: resp_valid in cycle 2.
  - Load with rvalid one cycle after grant: resp_valid in cycle 3.
  - Error: resp_valid in cycle 1.
- Byte lanes, o = addr[1:0]:
  - SB: be=4'b0001<<o, wdata={4{wdata[7:0]}}.
  - SH: be = 4'b0011 if o=0, 4'b1100 if o=2; wdata={2{wdata[15:0]}}.
  - SW: be=4'b1111.
  - Loads drive be=4'b1111, mem_we=0, mem_wdata=0.
- Load extension:
  - LB/LBU: byte rdata[8o+7:8o], sign- or zero-extended.
  - LH/LHU: half at o (0 or 2), sign- or zero-extended.
  - LW: full word.
- mem_addr always has bits [1:0]=0.
- Reset mid-transaction abandons it: mem_req drops, no resp_valid is produced, and any late mem_rvalid is ignored.

Decomposition:
- Shared package lsu_pkg:
  - state enum lsu_state_t (IDLE, ISSUE, WAIT_R, DONE).
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
- One combinational sub-module, lsu_lane_align: computes mem_be and mem_wdata from funct3/offset/wdata, load extension from funct3/offset/rdata, and the misalign/illegal flag.
- The FSM and registers stay in load_store_unit.

Test Plan:
- SB addr=0x0000_0013, wdata=0x0000_00AB, gnt at cycle 1 -> mem_addr=0x10, be=4'b1000, mem_wdata=0xABABABAB, mem_we=1; resp_valid at cycle 2, err=0.
- LB addr=0x0000_0021, mem_rdata=0x1234_80FF, rvalid 1 cycle after gnt -> resp_rdata=0xFFFF_FF80; same access as LBU -> 0x0000_0080.
- LH addr=0x0000_0042, mem_rdata=0x8001_0000 -> resp_rdata=0xFFFF_8001; LHU -> 0x0000_8001; be=4'b1111, mem_we=0.
- LW addr=0x0000_0006 -> no mem_req ever asserted; resp_valid at cycle 1 with err=1, rdata=0. Same for funct3=3 loads and SH at addr 0x1.
- SW with mem_gnt held low for 5 cycles -> mem_req and all mem_* outputs stable for 6 cycles; req_ready=0 throughout; resp_valid 1 cycle after the gnt cycle.
- LW granted, rst_n=0 before rvalid -> IDLE and req_ready=1 after the edge, no resp_valid; the later mem_rvalid is ignored.
